// File: rtl/bptc_collect_pkg.sv
// Shared types and MISR helper for the bptc pair collector.
// The MISR is used only when BPTC_COLLECT_SIG_EN is defined.
package bptc_collect_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        FLUSH
    } state_t;

    localparam logic [31:0] SIG_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] SIG_SEED = 32'hFFFF_FFFF;

    function automatic logic [31:0] misr_next(input logic [31:0] sig, input logic [31:0] data);
        return {sig[30:0], 1'b0} ^ (sig[31] ? SIG_POLY : 32'h0) ^ data;
    endfunction

endpackage

// File: rtl/bptc_sync_fifo.sv
// Synchronous FIFO with a registered head word.
// Push while full is accepted only when a pop happens in the same cycle.
module bptc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // dout keeps the last head once the FIFO drains, so it tracks the
    // next head explicitly rather than reading mem[rd_ptr].
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
            if (push_ok && (empty || (pop_ok && count == CW'(1)))) begin
                dout <= din;
            end else if (pop_ok && count > CW'(1)) begin
                dout <= mem[rd_ptr + AW'(1)];
            end
        end
    end

endmodule

// File: rtl/bptc_pair_collector.sv
// Deserialises the pout1/pout2 lanes into word pairs and queues them for a valid/ready consumer.
// Optional word signature (MISR) enabled by defining BPTC_COLLECT_SIG_EN.
//
// state   | meaning
// IDLE    | waiting for start; samples ignored
// COLLECT | shifting in en-qualified samples, pushing each full word
// FLUSH   | one cycle pushing the zero-padded partial word
module bptc_pair_collector
    import bptc_collect_pkg::*;
#(
    parameter int WORD_BITS = 8,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   en,
    input  logic                   pout1,
    input  logic                   pout2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WORD_BITS-1:0] out_data,
    output logic [4:0]             out_nbits,
    output logic                   overflow,
    output logic                   busy,
    output logic [31:0]            sig
);

    localparam int FW = 2 * WORD_BITS + 5;

    state_t                 state;
    logic [4:0]             cnt;
    logic [WORD_BITS-1:0]   sh_a;
    logic [WORD_BITS-1:0]   sh_b;

    logic [WORD_BITS-1:0]   a_smp;
    logic [WORD_BITS-1:0]   b_smp;
    logic [4:0]             cnt_inc;
    logic [4:0]             cnt_post;
    logic                   smp;
    logic                   word_done;
    logic                   push;
    logic [FW-1:0]          push_word;
    logic                   pop;
    logic                   accepted;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FW-1:0]          fifo_dout;

    always_comb begin
        a_smp     = sh_a | (WORD_BITS'(pout1) << cnt);
        b_smp     = sh_b | (WORD_BITS'(pout2) << cnt);
        cnt_inc   = cnt + 5'd1;
        smp       = (state == COLLECT) && en;
        word_done = smp && (cnt_inc == 5'(WORD_BITS));
        push      = word_done || (state == FLUSH);
        cnt_post  = cnt;
        if (smp) begin
            cnt_post = word_done ? 5'd0 : cnt_inc;
        end
        if (state == FLUSH) begin
            push_word = {cnt, sh_b, sh_a};
        end else begin
            push_word = {5'(WORD_BITS), b_smp, a_smp};
        end
    end

    assign pop       = out_valid && out_ready;
    assign accepted  = push && (!fifo_full || pop);
    assign out_valid = !fifo_empty;
    assign out_nbits = fifo_dout[FW-1 -: 5];
    assign out_data  = fifo_dout[2*WORD_BITS-1:0];
    assign busy      = (state != IDLE);

`ifdef BPTC_COLLECT_SIG_EN
    logic [31:0] sig_q;
    assign sig = sig_q;
`else
    assign sig = SIG_SEED;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sh_a     <= '0;
            sh_b     <= '0;
            overflow <= 1'b0;
`ifdef BPTC_COLLECT_SIG_EN
            sig_q    <= SIG_SEED;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= COLLECT;
                        cnt      <= '0;
                        sh_a     <= '0;
                        sh_b     <= '0;
                        overflow <= 1'b0;
`ifdef BPTC_COLLECT_SIG_EN
                        sig_q    <= SIG_SEED;
`endif
                    end
                end
                COLLECT: begin
                    if (smp) begin
                        cnt  <= cnt_post;
                        sh_a <= word_done ? '0 : a_smp;
                        sh_b <= word_done ? '0 : b_smp;
                    end
                    // the same-cycle sample decides whether a partial word remains
                    if (stop) begin
                        state <= (cnt_post == 5'd0) ? IDLE : FLUSH;
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                    cnt   <= '0;
                    sh_a  <= '0;
                    sh_b  <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (push && !accepted) begin
                overflow <= 1'b1;
            end
`ifdef BPTC_COLLECT_SIG_EN
            if (accepted) begin
                sig_q <= misr_next(sig_q, 32'(push_word[2*WORD_BITS-1:0]));
            end
`endif
        end
    end

    bptc_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

endmodule

// File: tb/tb_bptc_pair_collector.sv
// Scoreboard bench for bptc_pair_collector (WORD_BITS=8, DEPTH=4).
// Signature checks follow BPTC_COLLECT_SIG_EN when it is defined for the build.
module tb_bptc_pair_collector;

`ifdef BPTC_COLLECT_SIG_EN
    localparam bit SIG_EN = 1'b1;
`else
    localparam bit SIG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        en = 1'b0;
    logic        pout1 = 1'b0;
    logic        pout2 = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] out_data;
    logic [4:0]  out_nbits;
    logic        overflow;
    logic        busy;
    logic [31:0] sig;

    typedef struct {
        logic [15:0] d;
        logic [4:0]  n;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          pops = 0;
    logic [31:0] exp_sig = 32'hFFFF_FFFF;

    bptc_pair_collector #(.WORD_BITS(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .en        (en),
        .pout1     (pout1),
        .pout2     (pout2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_nbits (out_nbits),
        .overflow  (overflow),
        .busy      (busy),
        .sig       (sig)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    // A transfer happens at the posedge following a negedge with valid&ready.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            exp_t e;
            pops++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got data=%h nbits=%0d, required no word", out_data, out_nbits);
            end else begin
                e = sb.pop_front();
                if (out_data !== e.d || out_nbits !== e.n) begin
                    n_fail++;
                    $display("FAIL pop_word: got data=%h nbits=%0d, required data=%h nbits=%0d",
                             out_data, out_nbits, e.d, e.n);
                end
            end
        end
    end

    function automatic logic [31:0] ref_misr(input logic [31:0] s, input logic [31:0] d);
        logic [31:0] r;
        r = {s[30:0], 1'b0};
        if (s[31]) r = r ^ 32'h04C1_1DB7;
        return r ^ d;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        exp_sig = 32'hFFFF_FFFF;
    endtask

    task automatic sig_acc(input logic [15:0] w);
        if (SIG_EN) exp_sig = ref_misr(exp_sig, {16'h0, w});
    endtask

    task automatic send_word(input logic [7:0] a, input logic [7:0] b, input bit acc,
                             input bit stop_last, input bit ready_last);
        for (int i = 0; i < 8; i++) begin
            en = 1'b1;
            pout1 = a[i];
            pout2 = b[i];
            if (i == 7) begin
                stop = stop_last;
                if (ready_last) out_ready = 1'b1;
                if (acc) begin
                    sb.push_back('{d: {b, a}, n: 5'd8});
                    sig_acc({b, a});
                end
            end
            cyc();
        end
        en = 1'b0;
        stop = 1'b0;
        pout1 = 1'b0;
        pout2 = 1'b0;
        if (ready_last) out_ready = 1'b0;
    endtask

    task automatic drain(input string name, input int n_exp);
        int p0;
        int k;
        p0 = pops;
        k = 0;
        out_ready = 1'b1;
        while (out_valid === 1'b1 && k < 20) begin
            cyc();
            k++;
        end
        out_ready = 1'b0;
        n_checks++;
        if (k >= 20) begin
            n_fail++;
            $display("FAIL %s_drain_timeout: out_valid still %b after %0d cycles, required 0", name, out_valid, k);
        end
        n_checks++;
        if (pops - p0 != n_exp) begin
            n_fail++;
            $display("FAIL %s_drain_count: got %0d words, required %0d", name, pops - p0, n_exp);
        end
    endtask

    task automatic stop_idle();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        start = 1'b0;
        cyc();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
        n_checks++; if (out_data !== 16'h0 || out_nbits !== 5'd0) begin n_fail++; $display("FAIL rst_head: got %h/%0d, required 0000/0", out_data, out_nbits); end
        n_checks++; if (sig !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_sig: got %h, required ffffffff", sig); end
    endtask

    task automatic test_full_word();
        out_ready = 1'b0;
        do_start();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fw_busy: got %b, required 1", busy); end
        send_word(8'h8D, 8'hFF, 1'b1, 1'b0, 1'b0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fw_valid: got %b, required 1", out_valid); end
        n_checks++; if (out_data !== 16'hFF8D || out_nbits !== 5'd8) begin n_fail++; $display("FAIL fw_head: got %h/%0d, required ff8d/8", out_data, out_nbits); end
        n_checks++; if (sig !== exp_sig) begin n_fail++; $display("FAIL fw_sig: got %h, required %h", sig, exp_sig); end
        stop_idle();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fw_stop_idle: busy %b, required 0", busy); end
        drain("fw", 1);
    endtask

    task automatic test_backpressure();
        logic [7:0] wa [5] = '{8'h11, 8'h33, 8'h55, 8'h77, 8'h99};
        logic [7:0] wb [5] = '{8'h22, 8'h44, 8'h66, 8'h88, 8'hAA};
        out_ready = 1'b0;
        do_start();
        for (int w = 0; w < 5; w++) begin
            send_word(wa[w], wb[w], w < 4, 1'b0, 1'b0);
            if (w == 3) begin
                n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_ovf_at_full: got %b, required 0", overflow); end
            end
        end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow: got %b, required 1", overflow); end
        n_checks++; if (out_data !== 16'h2211) begin n_fail++; $display("FAIL bp_head: got %h, required 2211", out_data); end
        n_checks++; if (sig !== exp_sig) begin n_fail++; $display("FAIL bp_sig: got %h, required %h", sig, exp_sig); end
        drain("bp", 4);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_ovf_sticky: got %b, required 1", overflow); end
        stop_idle();
    endtask

    task automatic test_push_full_pop();
        out_ready = 1'b0;
        do_start();
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pfp_start_clr: got %b, required 0", overflow); end
        send_word(8'h01, 8'h10, 1'b1, 1'b0, 1'b0);
        send_word(8'h02, 8'h20, 1'b1, 1'b0, 1'b0);
        send_word(8'h03, 8'h30, 1'b1, 1'b0, 1'b0);
        send_word(8'h04, 8'h40, 1'b1, 1'b0, 1'b0);
        send_word(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b1);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pfp_overflow: got %b, required 0", overflow); end
        n_checks++; if (out_data !== 16'h2002) begin n_fail++; $display("FAIL pfp_head: got %h, required 2002", out_data); end
        n_checks++; if (sig !== exp_sig) begin n_fail++; $display("FAIL pfp_sig: got %h, required %h", sig, exp_sig); end
        drain("pfp", 4);
        stop_idle();
    endtask

    task automatic test_flush();
        logic [2:0] fa;
        logic [2:0] fb;
        fa = 3'b011;
        fb = 3'b110;
        out_ready = 1'b0;
        do_start();
        for (int i = 0; i < 3; i++) begin
            en = 1'b1;
            pout1 = fa[i];
            pout2 = fb[i];
            if (i == 2) begin
                stop = 1'b1;
                sb.push_back('{d: 16'h0603, n: 5'd3});
                sig_acc(16'h0603);
            end
            cyc();
        end
        stop = 1'b0;
        pout1 = 1'b1;
        pout2 = 1'b1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fl_in_flush: busy %b, required 1", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_early: out_valid %b, required 0", out_valid); end
        cyc();
        en = 1'b0;
        pout1 = 1'b0;
        pout2 = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fl_idle: busy %b, required 0", busy); end
        n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h0603 || out_nbits !== 5'd3) begin n_fail++; $display("FAIL fl_head: got v=%b %h/%0d, required 1 0603/3", out_valid, out_data, out_nbits); end
        n_checks++; if (sig !== exp_sig) begin n_fail++; $display("FAIL fl_sig: got %h, required %h", sig, exp_sig); end
        drain("fl", 1);
    endtask

    task automatic test_stop_full();
        out_ready = 1'b0;
        do_start();
        send_word(8'hC3, 8'h5A, 1'b1, 1'b1, 1'b0);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sf_idle: busy %b, required 0", busy); end
        n_checks++; if (out_data !== 16'h5AC3 || out_nbits !== 5'd8) begin n_fail++; $display("FAIL sf_head: got %h/%0d, required 5ac3/8", out_data, out_nbits); end
        cyc();
        cyc();
        drain("sf", 1);
    endtask

    task automatic test_midop_reset();
        out_ready = 1'b0;
        do_start();
        send_word(8'hDE, 8'hAD, 1'b0, 1'b0, 1'b0);
        send_word(8'hBE, 8'hEF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            en = 1'b1;
            pout1 = 1'b1;
            pout2 = 1'b1;
            cyc();
        end
        en = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_sig = 32'hFFFF_FFFF;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_valid: got %b, required 0", out_valid); end
        n_checks++; if (busy !== 1'b0 || out_data !== 16'h0) begin n_fail++; $display("FAIL mr_state: busy %b data %h, required 0 0000", busy, out_data); end
        n_checks++; if (sig !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mr_sig: got %h, required ffffffff", sig); end
        do_start();
        send_word(8'hE7, 8'h18, 1'b1, 1'b0, 1'b0);
        n_checks++; if (out_data !== 16'h18E7 || out_nbits !== 5'd8) begin n_fail++; $display("FAIL mr_new_word: got %h/%0d, required 18e7/8", out_data, out_nbits); end
        n_checks++; if (sig !== exp_sig) begin n_fail++; $display("FAIL mr_sig_new: got %h, required %h", sig, exp_sig); end
        drain("mr", 1);
        stop_idle();
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_backpressure();
        test_push_full_pop();
        test_flush();
        test_stop_full();
        test_midop_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
